chess_clock: RTL and testbench

CHESS_CLOCK -- requirements
Module: chess_clock

---
 rtl/chess_clock_if.sv | 33 +++
 rtl/chess_clock.sv | 194 +++++++++++++++++++
 tb/tb_chess_clock.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_clock_if.sv
// Signal bundle between the chess clock and its surroundings: three raw
// push-buttons in, tick/game status out, plus the FSM state for observation.
interface chess_clock_if;
    // No valid/ready handshake: buttons are asynchronous levels, and every
    // output is a registered level or a one-clk-cycle pulse.
    logic       button1;
    logic       button2;
    logic       start_button;
    logic       clk_one;
    logic       clk_four;
    logic       start;
    logic       game_clear;
    logic       player;
    logic       zero1;
    logic       zero2;
    logic [2:0] timer1;
    logic [2:0] timer2;
    logic       deb_button1;
    logic       deb_button2;
    logic [1:0] fsm_state;

    modport master (
        output button1, button2, start_button,
        input  clk_one, clk_four, start, game_clear, player, zero1, zero2,
        input  timer1, timer2, deb_button1, deb_button2, fsm_state
    );

    modport slave (
        input  button1, button2, start_button,
        output clk_one, clk_four, start, game_clear, player, zero1, zero2,
        output timer1, timer2, deb_button1, deb_button2, fsm_state
    );
endinterface

// File: rtl/chess_clock.sv
// Two-player chess clock: tick divider, button synchronise/debounce, game FSM.
// Optional macro CHESS_CLOCK_INCREMENT_EN adds one unit to the mover's timer on each turn switch.
module chess_clock #(
    parameter int unsigned FOUR_DIV    = 4,
    parameter int unsigned ONE_DIV     = 4,
    parameter int unsigned DEB_SAMPLES = 2,
    parameter logic [2:0]  TIME_INIT   = 3'd7
) (
    input logic          clk,
    input logic          reset,
    chess_clock_if.slave io
);

    localparam int FW = $clog2(FOUR_DIV);
    localparam int OW = $clog2(ONE_DIV);
    localparam int DW = $clog2(DEB_SAMPLES + 1);
    localparam logic [FW-1:0] FOUR_LAST = FW'(FOUR_DIV - 1);
    localparam logic [OW-1:0] ONE_LAST  = OW'(ONE_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    logic [FW-1:0] four_cnt;
    logic [OW-1:0] one_cnt;
    logic          four_tick;
    logic          clk_four_q;
    logic          clk_one_q;

    // four_tick is the edge that raises clk_four; debounce samples on it so a
    // press becomes visible in the same cycle as the clk_four/clk_one pulse.
    assign four_tick = (four_cnt == FOUR_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            four_cnt   <= '0;
            one_cnt    <= '0;
            clk_four_q <= 1'b0;
            clk_one_q  <= 1'b0;
        end else begin
            clk_four_q <= four_tick;
            clk_one_q  <= 1'b0;
            if (four_tick) begin
                four_cnt <= '0;
                if (one_cnt == ONE_LAST) begin
                    one_cnt   <= '0;
                    clk_one_q <= 1'b1;
                end else begin
                    one_cnt <= one_cnt + OW'(1);
                end
            end else begin
                four_cnt <= four_cnt + FW'(1);
            end
        end
    end

    // Bit 0 = button1, bit 1 = button2, bit 2 = start_button.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_prev;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];

    assign raw   = {io.start_button, io.button2, io.button1};
    assign press = deb & ~deb_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            if (four_tick) begin
                for (int i = 0; i < 3; i++) begin
                    if (sync2[i] == deb[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end
            end
        end
    end

    state_t     state;
    logic [2:0] timer1_q;
    logic [2:0] timer2_q;
    logic       player_q;
    logic       zero1_q;
    logic       zero2_q;
    logic       start_q;
    logic       game_clear_q;

    logic [2:0] cur_time;
    logic [2:0] cur_dec;
    logic [2:0] cur_next;
    logic       hits_zero;
    logic       switch_turn;

    // Everything below concerns only the running player's timer.
    always_comb begin
        cur_time    = player_q ? timer2_q : timer1_q;
        hits_zero   = clk_one_q && (cur_time <= 3'd1);
        cur_dec     = clk_one_q ? (cur_time - 3'd1) : cur_time;
        switch_turn = player_q ? press[1] : press[0];
`ifdef CHESS_CLOCK_INCREMENT_EN
        cur_next = (switch_turn && (cur_dec != 3'd7)) ? (cur_dec + 3'd1) : cur_dec;
`else
        cur_next = cur_dec;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer1_q     <= TIME_INIT;
            timer2_q     <= TIME_INIT;
            player_q     <= 1'b0;
            zero1_q      <= 1'b0;
            zero2_q      <= 1'b0;
            start_q      <= 1'b0;
            game_clear_q <= 1'b0;
        end else begin
            game_clear_q <= 1'b0;
            if (press[2]) begin
                state        <= RUN;
                timer1_q     <= TIME_INIT;
                timer2_q     <= TIME_INIT;
                player_q     <= 1'b0;
                zero1_q      <= 1'b0;
                zero2_q      <= 1'b0;
                start_q      <= 1'b1;
                game_clear_q <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        // A timer reaching zero beats a same-cycle turn switch.
                        if (hits_zero) begin
                            state   <= OVER;
                            start_q <= 1'b0;
                            if (player_q) begin
                                timer2_q <= 3'd0;
                                zero2_q  <= 1'b1;
                            end else begin
                                timer1_q <= 3'd0;
                                zero1_q  <= 1'b1;
                            end
                        end else begin
                            if (player_q) begin
                                timer2_q <= cur_next;
                            end else begin
                                timer1_q <= cur_next;
                            end
                            if (switch_turn) begin
                                player_q <= ~player_q;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign io.clk_four    = clk_four_q;
    assign io.clk_one     = clk_one_q;
    assign io.start       = start_q;
    assign io.game_clear  = game_clear_q;
    assign io.player      = player_q;
    assign io.zero1       = zero1_q;
    assign io.zero2       = zero2_q;
    assign io.timer1      = timer1_q;
    assign io.timer2      = timer2_q;
    assign io.deb_button1 = deb[0];
    assign io.deb_button2 = deb[1];
    assign io.fsm_state   = state;

endmodule

// File: tb/tb_chess_clock.sv
// Bench for chess_clock: per-cycle reference model, a table of button scenarios,
// a hand-timed zero/press collision sequence and a randomized soak.
`timescale 1ns/1ps
module tb_chess_clock;
    localparam int FD = 2;
    localparam int OD = 4;
    localparam int DS = 2;
    localparam logic [2:0] TI = 3'd7;
`ifdef CHESS_CLOCK_INCREMENT_EN
    localparam logic [2:0] INC = 3'd1;
`else
    localparam logic [2:0] INC = 3'd0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    chess_clock_if io();

    chess_clock #(
        .FOUR_DIV(FD), .ONE_DIV(OD), .DEB_SAMPLES(DS), .TIME_INIT(TI)
    ) dut (
        .clk(clk), .reset(reset), .io(io)
    );

    always #5 clk = ~clk;

    // Reference model: n counts edges since reset release, values are what
    // the outputs should hold after edge n.
    int         n = 0;
    logic       model_valid = 1'b0;
    logic [2:0] in_q[$];
    logic [2:0] samp_q[$];
    logic [2:0] m_deb, m_press;
    logic       m_four, m_one, m_run, m_gc, m_player;
    logic [1:0] m_zero;
    int         m_t[2];

    task model_step;
        logic [2:0] inp;
        logic [2:0] old;
        logic       flip_ok;
        int         mv;
        if (reset) begin
            n = 0;
            in_q.delete();
            in_q.push_back(3'b000);
            in_q.push_back(3'b000);
            samp_q.delete();
            m_deb = '0; m_press = '0; m_four = 1'b0; m_one = 1'b0;
            m_run = 1'b0; m_gc = 1'b0; m_player = 1'b0; m_zero = '0;
            m_t[0] = TI; m_t[1] = TI;
            model_valid = 1'b1;
        end else if (model_valid) begin
            n++;
            m_gc = 1'b0;
            if (m_press[2]) begin
                m_t[0] = TI; m_t[1] = TI; m_player = 1'b0; m_zero = '0;
                m_run = 1'b1; m_gc = 1'b1;
            end else if (m_run) begin
                mv = m_player ? 1 : 0;
                if (m_one && m_t[mv] <= 1) begin
                    m_t[mv] = 0; m_zero[mv] = 1'b1; m_run = 1'b0;
                end else begin
                    if (m_one) m_t[mv]--;
                    if ((!m_player && m_press[0]) || (m_player && m_press[1])) begin
                        if (INC != 3'd0 && m_t[mv] < 7) m_t[mv]++;
                        m_player = ~m_player;
                    end
                end
            end
            m_four = (n % FD == 0);
            m_one  = (n % (FD * OD) == 0);
            in_q.push_back({io.start_button, io.button2, io.button1});
            inp = in_q.pop_front();
            old = m_deb;
            if (m_four) begin
                samp_q.push_back(inp);
                if (samp_q.size() > DS) void'(samp_q.pop_front());
                if (samp_q.size() == DS) begin
                    for (int b = 0; b < 3; b++) begin
                        flip_ok = 1'b1;
                        foreach (samp_q[k]) if (samp_q[k][b] == m_deb[b]) flip_ok = 1'b0;
                        if (flip_ok) m_deb[b] = ~m_deb[b];
                    end
                end
            end
            m_press = m_deb & ~old;
        end
    endtask

    always @(posedge clk) model_step();

    logic [14:0] exp_v, act_v;
    logic        seen1, seen2;
    int          gc_count;

    always @(negedge clk) begin
        if (io.deb_button1) seen1 = 1'b1;
        if (io.deb_button2) seen2 = 1'b1;
        if (io.game_clear) gc_count++;
        if (model_valid) begin
            exp_v = {m_four, m_one, m_run, m_gc, m_player, m_zero[0], m_zero[1],
                     3'(m_t[0]), 3'(m_t[1]), m_deb[0], m_deb[1]};
            act_v = {io.clk_four, io.clk_one, io.start, io.game_clear, io.player,
                     io.zero1, io.zero2, io.timer1, io.timer2, io.deb_button1, io.deb_button2};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model n=%0d got=%b want=%b (four,one,start,gc,player,z1,z2,t1,t2,d1,d2)",
                         n, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (n < k && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (n != k) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached %0d expected %0d", n, k);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io.button1 = 1'b0;
        io.button2 = 1'b0;
        io.start_button = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        int         l1;
        int         o2;
        int         l2;
        logic       player;
        logic [2:0] t1;
        logic [2:0] t2;
        logic       seen1;
        logic       seen2;
    } vec_t;

    vec_t tbl[10];
    int   hold;

    initial begin
        tbl[0] = '{1, 0, 0, 1'b0, 3'd4, 3'd7, 1'b0, 1'b0};
        tbl[1] = '{2, 0, 0, 1'b0, 3'd4, 3'd7, 1'b0, 1'b0};
        tbl[2] = '{3, 0, 0, 1'b0, 3'd4, 3'd7, 1'b0, 1'b0};
        tbl[3] = '{4, 0, 0, 1'b1, 3'd5 + INC, 3'd6, 1'b1, 1'b0};
        tbl[4] = '{6, 0, 0, 1'b1, 3'd5 + INC, 3'd6, 1'b1, 1'b0};
        tbl[5] = '{0, 0, 6, 1'b0, 3'd4, 3'd7, 1'b0, 1'b1};
        tbl[6] = '{6, 0, 6, 1'b1, 3'd5 + INC, 3'd6, 1'b1, 1'b1};
        tbl[7] = '{6, 0, 1, 1'b1, 3'd5 + INC, 3'd6, 1'b1, 1'b0};
        tbl[8] = '{6, 8, 1, 1'b1, 3'd5 + INC, 3'd6, 1'b1, 1'b0};
        tbl[9] = '{6, 8, 4, 1'b0, 3'd5 + INC, 3'd6 + INC, 1'b1, 1'b1};

        io.button1 = 1'b0;
        io.button2 = 1'b0;
        io.start_button = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_timer1", 8'(io.timer1), 8'(TI));
        check("rst_timer2", 8'(io.timer2), 8'(TI));
        check("rst_flags", 8'({io.start, io.zero1, io.zero2, io.game_clear, io.player,
                               io.clk_one, io.clk_four, io.deb_button1}), 8'd0);

        // Scenario table: fresh game, button pulses starting after edge 12, check at edge 30.
        for (int r = 0; r < 10; r++) begin
            do_reset();
            seen1 = 1'b0; seen2 = 1'b0; gc_count = 0;
            io.start_button = 1'b1;
            wait_cyc(7);
            check("start_gc", 8'(io.game_clear), 8'd1);
            check("start_run", 8'(io.start), 8'd1);
            wait_cyc(10);
            io.start_button = 1'b0;
            wait_cyc(12);
            for (int k = 1; k <= 12; k++) begin
                io.button1 = (k <= tbl[r].l1);
                io.button2 = (k > tbl[r].o2) && (k <= tbl[r].o2 + tbl[r].l2);
                wait_cyc(12 + k);
            end
            io.button1 = 1'b0;
            io.button2 = 1'b0;
            wait_cyc(30);
            check($sformatf("tbl%0d_player", r), 8'(io.player), 8'(tbl[r].player));
            check($sformatf("tbl%0d_timer1", r), 8'(io.timer1), 8'(tbl[r].t1));
            check($sformatf("tbl%0d_timer2", r), 8'(io.timer2), 8'(tbl[r].t2));
            check($sformatf("tbl%0d_deb1_seen", r), 8'(seen1), 8'(tbl[r].seen1));
            check($sformatf("tbl%0d_deb2_seen", r), 8'(seen2), 8'(tbl[r].seen2));
            check($sformatf("tbl%0d_gc_pulses", r), 8'(gc_count), 8'd1);
        end

        // Player 1 runs out; a button1 press lands on the same edge as 1 -> 0.
        do_reset();
        io.start_button = 1'b1;
        wait_cyc(10);
        io.start_button = 1'b0;
        wait_cyc(49);
        check("zero_pre_t1", 8'(io.timer1), 8'd1);
        wait_cyc(50);
        io.button1 = 1'b1;
        wait_cyc(56);
        io.button1 = 1'b0;
        check("zero_deb1", 8'(io.deb_button1), 8'd1);
        wait_cyc(57);
        check("zero_z1", 8'(io.zero1), 8'd1);
        check("zero_z2", 8'(io.zero2), 8'd0);
        check("zero_start", 8'(io.start), 8'd0);
        check("zero_player", 8'(io.player), 8'd0);
        check("zero_t1", 8'(io.timer1), 8'd0);
        check("zero_t2", 8'(io.timer2), 8'd7);
        wait_cyc(60);
        io.button1 = 1'b1;
        io.button2 = 1'b1;
        wait_cyc(66);
        io.button1 = 1'b0;
        io.button2 = 1'b0;
        wait_cyc(75);
        check("over_player", 8'(io.player), 8'd0);
        check("over_t1", 8'(io.timer1), 8'd0);
        check("over_t2", 8'(io.timer2), 8'd7);
        check("over_start", 8'(io.start), 8'd0);
        io.start_button = 1'b1;
        wait_cyc(81);
        check("restart_gc", 8'(io.game_clear), 8'd1);
        check("restart_start", 8'(io.start), 8'd1);
        wait_cyc(85);
        io.start_button = 1'b0;
        wait_cyc(86);
        check("restart_t1", 8'(io.timer1), 8'd7);
        check("restart_t2", 8'(io.timer2), 8'd7);
        check("restart_z1", 8'(io.zero1), 8'd0);
        check("restart_player", 8'(io.player), 8'd0);

        // Randomized soak including occasional mid-game resets.
        for (int i = 0; i < 700; i++) begin
            io.button1      = ($urandom_range(0, 2) == 0);
            io.button2      = ($urandom_range(0, 2) == 0);
            io.start_button = ($urandom_range(0, 24) == 0);
            reset           = ($urandom_range(0, 149) == 0);
            hold = $urandom_range(1, 6);
            repeat (hold) @(posedge clk);
            #1;
        end
        reset = 1'b0;
        io.button1 = 1'b0;
        io.button2 = 1'b0;
        io.start_button = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
